// File: rtl/tinker_mem_pkg.sv
// Shared types and constants for the Tinker unified-memory arbiter.
package tinker_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam int FETCH_BYTES       = 4;
    localparam int DATA_BYTES        = 8;
    localparam int DEFAULT_MEM_BYTES = 524288;

    // Last byte of the access is computed in 65 bits so a wrap past 2^64
    // shows up as out of range instead of aliasing to a low address.
    function automatic logic in_range(input logic [63:0] addr,
                                      input int          nbytes,
                                      input int          mem_bytes);
        logic [64:0] last_byte;
        last_byte = {1'b0, addr} + 65'(nbytes - 1);
        return (last_byte < 65'(mem_bytes));
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way combinational picker: bit 0 = fetch port, bit 1 = data port.
module rr_arbiter2
    import tinker_mem_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last_owner,
    input  logic       fixed_prio,
    output logic [1:0] grant
);

    // single requester wins outright; a tie goes to the port that did not win last, or to data when fixed
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            if (fixed_prio || (last_owner == OWN_IF)) begin
                grant = 2'b10;
            end else begin
                grant = 2'b01;
            end
        end
    end

endmodule

// File: rtl/tinker_mem_arbiter.sv
// Shares the unified Tinker memory between instruction fetch and data port,
// one fixed-latency access at a time.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | arbitrating; grant is combinational and latches the request
//   ACCESS | memory driven for MEM_LAT cycles; write strobe on the last one
//   RESP   | one-cycle rvalid (and err) pulse to the owner, no grants
module tinker_mem_arbiter
    import tinker_mem_pkg::*;
#(
    parameter int MEM_BYTES  = DEFAULT_MEM_BYTES,
    parameter int MEM_LAT    = 2,
    parameter int FIXED_PRIO = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [63:0] d_rdata,
    output logic        d_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    output logic        busy
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    arb_state_t       state;
    owner_t           last_owner;
    owner_t           owner;
    logic [63:0]      addr_q;
    logic [63:0]      wdata_q;
    logic             we_q;
    logic [CNT_W-1:0] count;
    logic [63:0]      rdata_q;
    logic             err_q;
    logic             if_rvalid_q;
    logic             d_rvalid_q;

    logic [1:0]       req_arb;
    logic [1:0]       grant;
    owner_t           sel_owner;
    logic [63:0]      sel_addr;
    logic [63:0]      sel_wdata;
    logic             sel_we;
    logic             sel_ok;

    // requests only count while idle and out of reset, so a grant is never lost
    assign req_arb = {d_req, if_req} & {2{(state == IDLE) && !reset}};

    rr_arbiter2 u_arb (
        .req        (req_arb),
        .last_owner (last_owner),
        .fixed_prio (FIXED_PRIO != 0),
        .grant      (grant)
    );

    // mux the winning request and range-check it before it is latched
    always_comb begin
        sel_owner = grant[1] ? OWN_D : OWN_IF;
        sel_addr  = grant[1] ? d_addr : if_addr;
        sel_wdata = grant[1] ? d_wdata : '0;
        sel_we    = grant[1] & d_we;
        sel_ok    = in_range(sel_addr, grant[1] ? DATA_BYTES : FETCH_BYTES, MEM_BYTES);
    end

    // sequencing FSM with latched request and registered response
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last_owner  <= OWN_D;
            owner       <= OWN_IF;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            count       <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
        end else begin
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant != 2'b00) begin
                        owner      <= sel_owner;
                        last_owner <= sel_owner;
                        addr_q     <= sel_addr;
                        wdata_q    <= sel_wdata;
                        we_q       <= sel_we;
                        rdata_q    <= '0;
                        if (sel_ok) begin
                            state <= ACCESS;
                            count <= CNT_W'(MEM_LAT - 1);
                            err_q <= 1'b0;
                        end else begin
                            state       <= RESP;
                            err_q       <= 1'b1;
                            if_rvalid_q <= (sel_owner == OWN_IF);
                            d_rvalid_q  <= (sel_owner == OWN_D);
                        end
                    end
                end
                ACCESS: begin
                    if (count == '0) begin
                        rdata_q     <= we_q ? 64'h0 : mem_rdata;
                        state       <= RESP;
                        if_rvalid_q <= (owner == OWN_IF);
                        d_rvalid_q  <= (owner == OWN_D);
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                RESP: begin
                    state   <= IDLE;
                    err_q   <= 1'b0;
                    rdata_q <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // memory side; the write strobe is held off during reset so an aborted store never lands
    assign busy      = (state != IDLE);
    assign mem_en    = (state == ACCESS);
    assign mem_we    = mem_en && we_q && (count == '0) && !reset;
    assign mem_addr  = mem_en ? addr_q : '0;
    assign mem_wdata = (mem_en && we_q) ? wdata_q : '0;

    // requester side; data and err are forced to zero outside the rvalid pulse
    assign if_gnt    = grant[0];
    assign d_gnt     = grant[1];
    assign if_rvalid = if_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign if_rdata  = if_rvalid_q ? rdata_q[31:0] : '0;
    assign d_rdata   = d_rvalid_q ? rdata_q : '0;
    assign if_err    = if_rvalid_q & err_q;
    assign d_err     = d_rvalid_q & err_q;

endmodule
